// File: rtl/core_pkg.sv
// core_pkg -- shared types for the memory arbiter.
//   Xlen        : data/address width of the core
//   arb_state_e : arbiter FSM states (IDLE -> REQ -> RSP)
//   arb_owner_e : which pipeline stage owns the outstanding transaction
//   mem_req_t   : latched bus request {addr, we, wdata, wmask}
package core_pkg;

   localparam int Xlen  = 32;
   localparam int MaskW = Xlen / 8;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_REQ,
      ARB_RSP
   } arb_state_e;

   typedef enum logic {
      OWN_FETCH,
      OWN_DATA
   } arb_owner_e;

   typedef struct packed {
      logic [Xlen-1:0]  addr;
      logic             we;
      logic [Xlen-1:0]  wdata;
      logic [MaskW-1:0] wmask;
   } mem_req_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr -- counts data grants made while fetch is waiting.
// Built only when MEM_ARB_STARVE_GUARD_EN is defined.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   idle_i           arbiter is in IDLE this cycle
//   fetch_waiting_i  fetch request valid
//   fetch_grant_i    fetch granted this cycle
//   data_grant_i     data granted this cycle
//   at_limit_o       count has reached StarveLimit; next grant must go to fetch
module mem_arb_starve_ctr #(
   parameter int StarveLimit = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic idle_i,
   input  logic fetch_waiting_i,
   input  logic fetch_grant_i,
   input  logic data_grant_i,
   output logic at_limit_o
);

   localparam int CntW = $clog2(StarveLimit + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (idle_i) begin
         // Any fetch grant, or fetch not asking at all, means nobody is starving.
         if (fetch_grant_i || !fetch_waiting_i) begin
            cnt_d = '0;
         end else if (data_grant_i && (cnt_q != CntW'(StarveLimit))) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_o = (cnt_q == CntW'(StarveLimit));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-port memory bus between fetch (IF) and
// load/store (MEM). One transaction outstanding at a time; data has priority.
// Optional macro MEM_ARB_STARVE_GUARD_EN: after StarveLimit consecutive data
// grants with fetch waiting, the next grant goes to fetch.
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   if_req_* / if_flush_i / if_rsp_*    fetch request, flush, response
//   dm_req_* / dm_rsp_*                 data request and response
//   mem_valid_o, mem_ready_i            bus request handshake
//   mem_addr_o/we_o/wdata_o/wmask_o     registered bus request fields
//   mem_rvalid_i, mem_rdata_i           bus response
module mem_arbiter
   import core_pkg::*;
#(
   parameter int StarveLimit = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             if_req_valid_i,
   output logic             if_req_ready_o,
   input  logic [Xlen-1:0]  if_req_addr_i,
   input  logic             if_flush_i,
   output logic             if_rsp_valid_o,
   output logic [Xlen-1:0]  if_rsp_data_o,
   input  logic             dm_req_valid_i,
   output logic             dm_req_ready_o,
   input  logic [Xlen-1:0]  dm_req_addr_i,
   input  logic             dm_req_we_i,
   input  logic [Xlen-1:0]  dm_req_wdata_i,
   input  logic [MaskW-1:0] dm_req_wmask_i,
   output logic             dm_rsp_valid_o,
   output logic [Xlen-1:0]  dm_rsp_rdata_o,
   output logic             mem_valid_o,
   input  logic             mem_ready_i,
   output logic [Xlen-1:0]  mem_addr_o,
   output logic             mem_we_o,
   output logic [Xlen-1:0]  mem_wdata_o,
   output logic [MaskW-1:0] mem_wmask_o,
   input  logic             mem_rvalid_i,
   input  logic [Xlen-1:0]  mem_rdata_i
);

   arb_state_e state_q, state_d;
   arb_owner_e owner_q, owner_d;
   mem_req_t   req_q, req_d;
   logic       drop_q, drop_d;

   logic idle;
   logic force_fetch;
   logic grant_data;
   logic grant_fetch;
   logic rsp_fire;

   assign idle = (state_q == ARB_IDLE);

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic at_limit;

   mem_arb_starve_ctr #(
      .StarveLimit(StarveLimit)
   ) u_starve_ctr (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .idle_i         (idle),
      .fetch_waiting_i(if_req_valid_i),
      .fetch_grant_i  (grant_fetch),
      .data_grant_i   (grant_data),
      .at_limit_o     (at_limit)
   );

   assign force_fetch = at_limit & if_req_valid_i;
`else
   logic unused_starve_limit;
   assign unused_starve_limit = ^StarveLimit;
   assign force_fetch         = 1'b0;
`endif

   assign grant_data  = idle & dm_req_valid_i & ~force_fetch;
   assign grant_fetch = idle & if_req_valid_i & (~dm_req_valid_i | force_fetch);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      req_d   = req_q;
      drop_d  = drop_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (grant_data) begin
               owner_d = OWN_DATA;
               req_d   = '{addr: dm_req_addr_i, we: dm_req_we_i,
                           wdata: dm_req_wdata_i, wmask: dm_req_wmask_i};
               state_d = ARB_REQ;
            end else if (grant_fetch) begin
               owner_d = OWN_FETCH;
               req_d   = '{addr: if_req_addr_i, we: 1'b0,
                           wdata: '0, wmask: '0};
               state_d = ARB_REQ;
            end
         end
         ARB_REQ: begin
            if (mem_ready_i) state_d = ARB_RSP;
         end
         ARB_RSP: begin
            if (mem_rvalid_i) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
      // A flush while fetch owns the bus poisons the response, which still
      // has to be collected from the bus before the next grant.
      if (!idle && (owner_q == OWN_FETCH) && if_flush_i) drop_d = 1'b1;
      if (state_d == ARB_IDLE) drop_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ARB_IDLE;
         owner_q <= OWN_FETCH;
         req_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         req_q   <= req_d;
         drop_q  <= drop_d;
      end
   end

   assign if_req_ready_o = grant_fetch;
   assign dm_req_ready_o = grant_data;

   assign mem_valid_o = (state_q == ARB_REQ);
   assign mem_addr_o  = req_q.addr;
   assign mem_we_o    = req_q.we;
   assign mem_wdata_o = req_q.wdata;
   assign mem_wmask_o = req_q.wmask;

   // A flush in the response cycle itself also suppresses the pulse.
   assign rsp_fire       = (state_q == ARB_RSP) & mem_rvalid_i;
   assign if_rsp_valid_o = rsp_fire & (owner_q == OWN_FETCH) & ~(drop_q | if_flush_i);
   assign dm_rsp_valid_o = rsp_fire & (owner_q == OWN_DATA);
   assign if_rsp_data_o  = if_rsp_valid_o ? mem_rdata_i : '0;
   assign dm_rsp_rdata_o = dm_rsp_valid_o ? mem_rdata_i : '0;

   rvalid_only_in_rsp: assert property (
      @(posedge clk_i) disable iff (!rst_ni) mem_rvalid_i |-> (state_q == ARB_RSP)
   ) else $error("mem_arbiter: mem_rvalid_i outside RSP ignored");

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
   import core_pkg::*;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             if_req_valid_i, if_req_ready_o, if_flush_i, if_rsp_valid_o;
   logic [Xlen-1:0]  if_req_addr_i, if_rsp_data_o;
   logic             dm_req_valid_i, dm_req_ready_o, dm_req_we_i, dm_rsp_valid_o;
   logic [Xlen-1:0]  dm_req_addr_i, dm_req_wdata_i, dm_rsp_rdata_o;
   logic [MaskW-1:0] dm_req_wmask_i, mem_wmask_o;
   logic             mem_valid_o, mem_ready_i, mem_we_o, mem_rvalid_i;
   logic [Xlen-1:0]  mem_addr_o, mem_wdata_o, mem_rdata_i;

   mem_arbiter #(.StarveLimit(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .if_req_valid_i(if_req_valid_i), .if_req_ready_o(if_req_ready_o),
      .if_req_addr_i(if_req_addr_i), .if_flush_i(if_flush_i),
      .if_rsp_valid_o(if_rsp_valid_o), .if_rsp_data_o(if_rsp_data_o),
      .dm_req_valid_i(dm_req_valid_i), .dm_req_ready_o(dm_req_ready_o),
      .dm_req_addr_i(dm_req_addr_i), .dm_req_we_i(dm_req_we_i),
      .dm_req_wdata_i(dm_req_wdata_i), .dm_req_wmask_i(dm_req_wmask_i),
      .dm_rsp_valid_o(dm_rsp_valid_o), .dm_rsp_rdata_o(dm_rsp_rdata_o),
      .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
      .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;

   // Transaction-level reference: one outstanding transaction, its owner and
   // fields, whether the bus took it, and when the bus will answer.
   bit               m_pend, m_acc, m_drop, m_data;
   int               m_wait, m_cnt, next_wait;
   logic [Xlen-1:0]  m_addr, m_wdata;
   logic             m_we;
   logic [MaskW-1:0] m_wmask;
   bit               bus_auto = 1'b1;

   int              if_pulses = 0, dm_pulses = 0;
   logic [Xlen-1:0] last_if_data = '0, last_dm_data = '0;
   bit              obs_grants[$];   // 1 = data grant, 0 = fetch grant

   int base_if, base_dm, gi, nsteps;
   bit b0, b1;
   logic [9:0] order, exp_order;

   task automatic chk(input string tag, input logic [Xlen-1:0] obs, input logic [Xlen-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_acc = 0; m_drop = 0; m_data = 0; m_wait = 0; m_cnt = 0;
      m_addr = '0; m_wdata = '0; m_we = 1'b0; m_wmask = '0;
   endtask

   task automatic set_idle();
      if_req_valid_i = 0; if_req_addr_i = '0; if_flush_i = 0;
      dm_req_valid_i = 0; dm_req_addr_i = '0; dm_req_we_i = 0;
      dm_req_wdata_i = '0; dm_req_wmask_i = '0;
      mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; next_wait = 0;
   endtask

   // One clock cycle: inputs are already set by the caller.
   task automatic step();
      bit force_f, e_dm, e_if, rsp, e_ifv, e_dmv;
      if (bus_auto) mem_rvalid_i = m_acc && (m_wait == 0);
      #1;
      force_f = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      force_f = (m_cnt >= 4) && if_req_valid_i;
`endif
      e_dm  = !m_pend && dm_req_valid_i && !force_f;
      e_if  = !m_pend && if_req_valid_i && !e_dm;
      rsp   = m_acc && mem_rvalid_i;
      e_ifv = rsp && !m_data && !(m_drop || if_flush_i);
      e_dmv = rsp && m_data;
      chk("dm_req_ready", dm_req_ready_o, e_dm);
      chk("if_req_ready", if_req_ready_o, e_if);
      chk("mem_valid", mem_valid_o, m_pend && !m_acc);
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_we", mem_we_o, m_we);
      chk("mem_wdata", mem_wdata_o, m_wdata);
      chk("mem_wmask", mem_wmask_o, m_wmask);
      chk("if_rsp_valid", if_rsp_valid_o, e_ifv);
      chk("if_rsp_data", if_rsp_data_o, e_ifv ? mem_rdata_i : '0);
      chk("dm_rsp_valid", dm_rsp_valid_o, e_dmv);
      chk("dm_rsp_data", dm_rsp_rdata_o, e_dmv ? mem_rdata_i : '0);
      if (if_rsp_valid_o) begin if_pulses++; last_if_data = if_rsp_data_o; end
      if (dm_rsp_valid_o) begin dm_pulses++; last_dm_data = dm_rsp_rdata_o; end
      if (dm_req_ready_o && dm_req_valid_i) obs_grants.push_back(1'b1);
      else if (if_req_ready_o && if_req_valid_i) obs_grants.push_back(1'b0);
      // Reference update for the coming edge.
      if (!m_pend) begin
         if (e_dm) begin
            m_pend = 1; m_data = 1; m_addr = dm_req_addr_i; m_we = dm_req_we_i;
            m_wdata = dm_req_wdata_i; m_wmask = dm_req_wmask_i;
         end else if (e_if) begin
            m_pend = 1; m_data = 0; m_addr = if_req_addr_i; m_we = 0;
            m_wdata = '0; m_wmask = '0;
         end
         if (e_if || !if_req_valid_i) m_cnt = 0;
         else if (e_dm) m_cnt++;
      end else begin
         if (!m_data && if_flush_i) m_drop = 1;
         if (rsp) begin
            m_pend = 0; m_acc = 0; m_drop = 0;
         end else if (!m_acc && mem_ready_i) begin
            m_acc = 1; m_wait = next_wait;
         end else if (m_acc && m_wait > 0) begin
            m_wait--;
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      set_idle();
      model_reset();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_mem_valid", mem_valid_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_mem_we", mem_we_o, 0);
      chk("rst_mem_wdata", mem_wdata_o, 0);
      chk("rst_mem_wmask", mem_wmask_o, 0);
      chk("rst_if_ready", if_req_ready_o, 0);
      chk("rst_dm_ready", dm_req_ready_o, 0);
      chk("rst_if_rsp", if_rsp_valid_o, 0);
      chk("rst_dm_rsp", dm_rsp_valid_o, 0);
      rst_ni = 1'b1;
      #1;

      // 1: lone fetch, zero-wait bus
      base_if = if_pulses; base_dm = dm_pulses;
      if_req_valid_i = 1; if_req_addr_i = 32'h100; mem_ready_i = 1;
      next_wait = 0; mem_rdata_i = 32'h0050_0093;
      step();
      if_req_valid_i = 0;
      step();
      chk("t1_mem_addr", mem_addr_o, 32'h100);
      step();
      chk("t1_if_pulses", if_pulses - base_if, 1);
      chk("t1_if_data", last_if_data, 32'h0050_0093);
      chk("t1_dm_pulses", dm_pulses - base_dm, 0);

      // 2: simultaneous fetch and data load, data first
      gi = obs_grants.size();
      dm_req_valid_i = 1; dm_req_addr_i = 32'h2000; dm_req_we_i = 0;
      if_req_valid_i = 1; if_req_addr_i = 32'h300; mem_rdata_i = 32'h1234_5678;
      step();
      b0 = (obs_grants.size() > gi) ? obs_grants[gi] : 1'b0;
      chk("t2_data_first", b0, 1);
      chk("t2_mem_addr", mem_addr_o, 32'h2000);
      dm_req_valid_i = 0;
      nsteps = 0;
      for (int c = 0; c < 10 && obs_grants.size() == gi + 1; c++) begin
         step();
         nsteps++;
      end
      b1 = (obs_grants.size() > gi + 1) ? obs_grants[gi + 1] : 1'b1;
      chk("t2_fetch_second", b1, 0);
      chk("t2_fetch_after_rsp", nsteps, 3);
      if_req_valid_i = 0;
      step(); step();

      // 3: store held off by the bus for three cycles
      base_dm = dm_pulses;
      dm_req_valid_i = 1; dm_req_addr_i = 32'h2004; dm_req_we_i = 1;
      dm_req_wdata_i = 32'hDEAD_BEEF; dm_req_wmask_i = 4'b0011; mem_ready_i = 0;
      step();
      dm_req_valid_i = 0; dm_req_wdata_i = 32'h0; dm_req_wmask_i = 4'b0; dm_req_we_i = 0;
      for (int c = 0; c < 3; c++) begin
         chk("t3_wdata_hold", mem_wdata_o, 32'hDEAD_BEEF);
         step();
      end
      mem_ready_i = 1;
      chk("t3_wmask_hold", mem_wmask_o, 4'b0011);
      step();
      step();
      chk("t3_dm_pulses", dm_pulses - base_dm, 1);

      // 4: flush of an in-flight fetch one cycle before the response
      base_if = if_pulses;
      if_req_valid_i = 1; if_req_addr_i = 32'h200; next_wait = 1; mem_rdata_i = 32'hAAAA_5555;
      step();
      if_req_valid_i = 0;
      step();
      if_flush_i = 1;
      step();
      if_flush_i = 0;
      step();
      chk("t4_flushed", if_pulses - base_if, 0);
      next_wait = 0; if_req_valid_i = 1; if_req_addr_i = 32'h204;
      step();
      if_req_valid_i = 0;
      step(); step();
      chk("t4_next_fetch", if_pulses - base_if, 1);

      // 5: reset in the middle of a request
      if_req_valid_i = 1; if_req_addr_i = 32'h300; mem_ready_i = 0;
      step();
      if_req_valid_i = 0;
      chk("t5_in_req", mem_valid_o, 1);
      rst_ni = 0;
      model_reset();
      #1;
      chk("t5_valid_rst", mem_valid_o, 0);
      @(posedge clk_i); #1;
      chk("t5_valid_next", mem_valid_o, 0);
      chk("t5_addr_rst", mem_addr_o, 0);
      bus_auto = 0; mem_rvalid_i = 1;
      #1;
      chk("t5_stray_if", if_rsp_valid_o, 0);
      chk("t5_stray_dm", dm_rsp_valid_o, 0);
      @(posedge clk_i); #1;
      mem_rvalid_i = 0; bus_auto = 1;
      rst_ni = 1;
      #1;
      if_req_valid_i = 1; if_req_addr_i = 32'h400; mem_ready_i = 1;
      step();
      if_req_valid_i = 0;
      step(); step();

      // 6: both requesters always valid
      rst_ni = 0; model_reset(); set_idle();
      @(posedge clk_i); #1;
      rst_ni = 1; #1;
      gi = obs_grants.size();
      if_req_valid_i = 1; if_req_addr_i = 32'h500;
      dm_req_valid_i = 1; dm_req_addr_i = 32'h3000; mem_ready_i = 1;
      for (int c = 0; c < 60 && obs_grants.size() < gi + 10; c++) step();
      for (int k = 0; k < 10; k++)
         order[9 - k] = (obs_grants.size() > gi + k) ? obs_grants[gi + k] : 1'bx;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_order = 10'b11110_11110;
`else
      exp_order = 10'b11111_11111;
`endif
      chk("t6_grant_order", order, exp_order);
      set_idle(); mem_ready_i = 1;
      step(); step(); step();

      // Random traffic against the reference
      for (int c = 0; c < 400; c++) begin
         if_req_valid_i = ($urandom_range(0, 3) != 0);
         if_req_addr_i  = $urandom();
         dm_req_valid_i = ($urandom_range(0, 2) == 0);
         dm_req_addr_i  = $urandom();
         dm_req_we_i    = $urandom_range(0, 1);
         dm_req_wdata_i = $urandom();
         dm_req_wmask_i = 4'($urandom_range(0, 15));
         if_flush_i     = ($urandom_range(0, 9) == 0);
         mem_ready_i    = $urandom_range(0, 1);
         next_wait      = $urandom_range(0, 2);
         mem_rdata_i    = $urandom();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
